timer_bank: RTL and testbench



---
 rtl/timer_pkg.sv | 19 +
 rtl/timer_bank_if.sv | 30 +++
 rtl/timer_channel.sv | 109 ++++++++++
 rtl/timer_bank.sv | 75 +++++++
 tb/tb_timer_bank.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared encodings for the timer bank: channel operating modes and channel FSM states.
package timer_pkg;

  localparam logic [1:0] MODE_ONESHOT   = 2'b00;
  localparam logic [1:0] MODE_PERIODIC  = 2'b01;
  localparam logic [1:0] MODE_STOPWATCH = 2'b10;

  typedef enum logic [1:0] {
    CH_IDLE = 2'b00,
    CH_RUN  = 2'b01,
    CH_HOLD = 2'b10
  } ch_state_e;

  // The reserved encoding 11 behaves exactly like one-shot.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'b11) ? MODE_ONESHOT : mode;
  endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Control/status bundle between the UART control logic (master) and the timer bank (slave).
interface timer_bank_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32
);
  logic [N_CH-1:0]       ch_start;
  logic [N_CH-1:0]       ch_stop;
  logic [2*N_CH-1:0]     ch_mode;
  logic [N_CH*CNT_W-1:0] ch_limit;
  logic [N_CH-1:0]       irq_en;
  logic [N_CH-1:0]       irq_clr;
  logic [N_CH*CNT_W-1:0] ch_count;
  logic [N_CH-1:0]       ch_busy;
  logic [N_CH-1:0]       ch_done;
  logic [N_CH-1:0]       ch_timeout;
  logic [N_CH-1:0]       irq_pend;
  logic                  irq;
  logic                  tick;
  logic [CNT_W-1:0]      timestamp;

  modport master (
    output ch_start, ch_stop, ch_mode, ch_limit, irq_en, irq_clr,
    input  ch_count, ch_busy, ch_done, ch_timeout, irq_pend, irq, tick, timestamp
  );

  modport slave (
    input  ch_start, ch_stop, ch_mode, ch_limit, irq_en, irq_clr,
    output ch_count, ch_busy, ch_done, ch_timeout, irq_pend, irq, tick, timestamp
  );
endinterface

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/HOLD FSM with one-shot, periodic and stopwatch behaviour,
// plus its sticky interrupt-pending bit.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] limit,
  input  logic             irq_clr,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             pend
);

  ch_state_e        state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             timeout_dly_q, timeout_dly_d;
  logic             pend_q, pend_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CH_IDLE;
      mode_q        <= MODE_ONESHOT;
      limit_q       <= '0;
      count_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      timeout_dly_q <= 1'b0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      limit_q       <= limit_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      timeout_dly_q <= timeout_dly_d;
      pend_q        <= pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    limit_d       = limit_q;
    count_d       = count_q;
    done_d        = 1'b0;
    timeout_d     = timeout_q;
    timeout_dly_d = timeout_q;

    // Start beats stop; a stop in RUN beats the terminal condition on the same edge.
    if (start) begin
      mode_d    = norm_mode(mode);
      limit_d   = limit;
      count_d   = '0;
      timeout_d = 1'b0;
      state_d   = CH_RUN;
    end else begin
      unique case (state_q)
        CH_RUN: begin
          if (stop) begin
            state_d = CH_HOLD;
          end else if (count_q == limit_q) begin
            unique case (mode_q)
              MODE_PERIODIC: begin
                done_d  = 1'b1;
                count_d = '0;
              end
              MODE_STOPWATCH: timeout_d = 1'b1;
              default: begin
                done_d  = 1'b1;
                state_d = CH_IDLE;
              end
            endcase
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        CH_HOLD: if (stop) state_d = CH_IDLE;
        default: ;
      endcase
    end

    busy_d = (state_d == CH_RUN);
    // Pending is raised one cycle after the done pulse or the timeout rising edge.
    pend_d = (pend_q & ~irq_clr) | done_q | (timeout_q & ~timeout_dly_q);
  end

  assign count   = count_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign pend    = pend_q;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel cycle timer bank with a free-running seconds timestamp.
// Channels are independent timer_channel instances; prescaler and irq OR live here.
module timer_bank #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 32,
  parameter int TS_DIV = 100_000_000
) (
  input logic         clk,
  input logic         rst,
  timer_bank_if.slave bus
);

  localparam int PS_W = $clog2(TS_DIV);

  logic [N_CH*CNT_W-1:0] count_w;
  logic [N_CH-1:0]       busy_w;
  logic [N_CH-1:0]       done_w;
  logic [N_CH-1:0]       timeout_w;
  logic [N_CH-1:0]       pend_w;

  logic [PS_W-1:0]       presc_q, presc_d;
  logic                  tick_q, tick_d;
  logic [CNT_W-1:0]      ts_q, ts_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .start   (bus.ch_start[i]),
      .stop    (bus.ch_stop[i]),
      .mode    (bus.ch_mode[2*i +: 2]),
      .limit   (bus.ch_limit[i*CNT_W +: CNT_W]),
      .irq_clr (bus.irq_clr[i]),
      .count   (count_w[i*CNT_W +: CNT_W]),
      .busy    (busy_w[i]),
      .done    (done_w[i]),
      .timeout (timeout_w[i]),
      .pend    (pend_w[i])
    );
  end

  // Prescaler runs 0..TS_DIV-1; its wrap produces the tick and bumps the timestamp.
  always_comb begin
    presc_d = presc_q + PS_W'(1);
    tick_d  = 1'b0;
    ts_d    = ts_q;
    if (presc_q == PS_W'(TS_DIV - 1)) begin
      presc_d = '0;
      tick_d  = 1'b1;
      ts_d    = ts_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      ts_q    <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      ts_q    <= ts_d;
    end
  end

  assign bus.ch_count   = count_w;
  assign bus.ch_busy    = busy_w;
  assign bus.ch_done    = done_w;
  assign bus.ch_timeout = timeout_w;
  assign bus.irq_pend   = pend_w;
  assign bus.irq        = |(pend_w & bus.irq_en);
  assign bus.tick       = tick_q;
  assign bus.timestamp  = ts_q;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against an elapsed-time reference model.
module tb_timer_bank;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int DIV = 10;

  logic clk;
  logic rst;

  timer_bank_if #(.N_CH(N), .CNT_W(W)) bus_if ();

  timer_bank #(.N_CH(N), .CNT_W(W), .TS_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] drv_start   = '0;
  logic [N-1:0] drv_stop    = '0;
  logic [N-1:0] drv_irq_en  = '0;
  logic [N-1:0] drv_irq_clr = '0;
  logic [1:0]   drv_mode [N];
  logic [W-1:0] drv_limit [N];
  logic         drv_rst = 1'b0;

  // Reference model: phase 0 idle / 1 run / 2 hold, elapsed run cycles since start.
  int     m_ph [N];
  int     m_mode [N];
  longint m_lim [N];
  longint m_e [N];
  longint m_cnt [N];
  bit     m_done [N];
  bit     m_to [N];
  bit     m_to_prev [N];
  bit     m_pend [N];
  longint m_r;

  typedef struct {
    int         cyc;
    int         ch;
    logic       drv;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    int         limit;
    logic       chk;
    int         exp_count;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_to;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkDrv(int cyc, int ch, logic start, logic stop, logic [1:0] mode, int limit);
    vec_t v;
    v.cyc = cyc; v.ch = ch; v.drv = 1'b1; v.start = start; v.stop = stop; v.mode = mode;
    v.limit = limit; v.chk = 1'b0; v.exp_count = 0; v.exp_busy = 1'b0; v.exp_done = 1'b0;
    v.exp_to = 1'b0;
    return v;
  endfunction

  function automatic vec_t mkChk(int cyc, int ch, int cnt, logic busy, logic done, logic to);
    vec_t v;
    v.cyc = cyc; v.ch = ch; v.drv = 1'b0; v.start = 1'b0; v.stop = 1'b0; v.mode = 2'b00;
    v.limit = 0; v.chk = 1'b1; v.exp_count = cnt; v.exp_busy = busy; v.exp_done = done;
    v.exp_to = to;
    return v;
  endfunction

  function automatic longint dutCount(int i);
    return longint'(bus_if.ch_count[i*W +: W]);
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic modelStep();
    bit od, ot, otp;
    if (drv_rst) begin
      m_r = 0;
      for (int i = 0; i < N; i++) begin
        m_ph[i] = 0; m_mode[i] = 0; m_lim[i] = 0; m_e[i] = 0; m_cnt[i] = 0;
        m_done[i] = 0; m_to[i] = 0; m_to_prev[i] = 0; m_pend[i] = 0;
      end
      return;
    end
    m_r++;
    for (int i = 0; i < N; i++) begin
      od = m_done[i];
      ot = m_to[i];
      otp = m_to_prev[i];
      m_pend[i] = (m_pend[i] && !drv_irq_clr[i]) || od || (ot && !otp);
      m_to_prev[i] = ot;
      m_done[i] = 0;
      if (drv_start[i]) begin
        m_mode[i] = (drv_mode[i] == 2'b01) ? 1 : (drv_mode[i] == 2'b10) ? 2 : 0;
        m_lim[i] = longint'(drv_limit[i]);
        m_e[i] = 0;
        m_cnt[i] = 0;
        m_to[i] = 0;
        m_ph[i] = 1;
      end else if (m_ph[i] == 1) begin
        if (drv_stop[i]) begin
          m_ph[i] = 2;
        end else begin
          m_e[i]++;
          case (m_mode[i])
            1: begin
              m_cnt[i] = m_e[i] % (m_lim[i] + 1);
              if (m_cnt[i] == 0) m_done[i] = 1;
            end
            2: begin
              if (m_e[i] > m_lim[i]) begin
                m_to[i] = 1;
                m_cnt[i] = m_lim[i];
              end else begin
                m_cnt[i] = m_e[i];
              end
            end
            default: begin
              if (m_e[i] == m_lim[i] + 1) begin
                m_done[i] = 1;
                m_ph[i] = 0;
                m_cnt[i] = m_lim[i];
              end else begin
                m_cnt[i] = m_e[i];
              end
            end
          endcase
        end
      end else if (m_ph[i] == 2 && drv_stop[i]) begin
        m_ph[i] = 0;
      end
    end
  endtask

  task automatic checkModel();
    bit any_irq;
    any_irq = 0;
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("model.ch%0d.count", i), dutCount(i), m_cnt[i]);
      checkOutput($sformatf("model.ch%0d.busy", i), longint'(bus_if.ch_busy[i]), longint'(m_ph[i] == 1));
      checkOutput($sformatf("model.ch%0d.done", i), longint'(bus_if.ch_done[i]), longint'(m_done[i]));
      checkOutput($sformatf("model.ch%0d.timeout", i), longint'(bus_if.ch_timeout[i]), longint'(m_to[i]));
      checkOutput($sformatf("model.ch%0d.pend", i), longint'(bus_if.irq_pend[i]), longint'(m_pend[i]));
      any_irq = any_irq | (m_pend[i] & drv_irq_en[i]);
    end
    checkOutput("model.irq", longint'(bus_if.irq), longint'(any_irq));
    checkOutput("model.tick", longint'(bus_if.tick), longint'(m_r > 0 && (m_r % DIV) == 0));
    checkOutput("model.timestamp", longint'(bus_if.timestamp), (m_r / DIV) & 64'hFFFF_FFFF);
  endtask

  // Drive the current drv_* values for one clock, advance the model, then compare at negedge.
  task automatic applyStimulus();
    rst = drv_rst;
    bus_if.ch_start = drv_start;
    bus_if.ch_stop  = drv_stop;
    bus_if.irq_en   = drv_irq_en;
    bus_if.irq_clr  = drv_irq_clr;
    for (int i = 0; i < N; i++) begin
      bus_if.ch_mode[2*i +: 2]  = drv_mode[i];
      bus_if.ch_limit[i*W +: W] = drv_limit[i];
    end
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkModel();
    drv_start   = '0;
    drv_stop    = '0;
    drv_irq_clr = '0;
    drv_rst     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      drv_mode[i] = 2'b00;
      drv_limit[i] = '0;
    end
    rst = 1'b1;
    bus_if.ch_start = '0; bus_if.ch_stop = '0; bus_if.irq_en = '0; bus_if.irq_clr = '0;
    bus_if.ch_mode = '0; bus_if.ch_limit = '0;
    @(negedge clk);
    drv_rst = 1'b1;
    applyStimulus();

    // Four channels concurrently: one-shot 10, periodic 3 (stopped), stopwatch 100 (stopped), one-shot 0.
    vecs.push_back(mkDrv(0, 0, 1'b1, 1'b0, 2'b00, 10));
    vecs.push_back(mkDrv(0, 1, 1'b1, 1'b0, 2'b01, 3));
    vecs.push_back(mkDrv(0, 2, 1'b1, 1'b0, 2'b10, 100));
    vecs.push_back(mkDrv(0, 3, 1'b1, 1'b0, 2'b11, 0));
    vecs.push_back(mkChk(1, 0, 0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mkChk(11, 0, 10, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mkChk(12, 0, 10, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mkChk(13, 0, 10, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkChk(30, 0, 10, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkChk(4, 1, 3, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mkChk(5, 1, 0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mkChk(9, 1, 0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mkChk(10, 1, 1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mkDrv(10, 1, 1'b0, 1'b1, 2'b01, 3));
    vecs.push_back(mkChk(11, 1, 1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkChk(13, 1, 1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkChk(51, 2, 50, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mkDrv(51, 2, 1'b0, 1'b1, 2'b10, 100));
    vecs.push_back(mkChk(52, 2, 50, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkChk(60, 2, 50, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkChk(1, 3, 0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mkChk(2, 3, 0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mkChk(3, 3, 0, 1'b0, 1'b0, 1'b0));

    for (int c = 0; c <= 60; c++) begin
      foreach (vecs[k]) begin
        if (vecs[k].cyc == c) begin
          if (vecs[k].chk) begin
            checkOutput($sformatf("vec%0d.ch%0d.count", k, vecs[k].ch), dutCount(vecs[k].ch), longint'(vecs[k].exp_count));
            checkOutput($sformatf("vec%0d.ch%0d.busy", k, vecs[k].ch), longint'(bus_if.ch_busy[vecs[k].ch]), longint'(vecs[k].exp_busy));
            checkOutput($sformatf("vec%0d.ch%0d.done", k, vecs[k].ch), longint'(bus_if.ch_done[vecs[k].ch]), longint'(vecs[k].exp_done));
            checkOutput($sformatf("vec%0d.ch%0d.timeout", k, vecs[k].ch), longint'(bus_if.ch_timeout[vecs[k].ch]), longint'(vecs[k].exp_to));
          end
          if (vecs[k].drv) begin
            drv_start[vecs[k].ch] = vecs[k].start;
            drv_stop[vecs[k].ch]  = vecs[k].stop;
            drv_mode[vecs[k].ch]  = vecs[k].mode;
            drv_limit[vecs[k].ch] = W'(vecs[k].limit);
          end
        end
      end
      if (c < 60) applyStimulus();
    end

    // Stopwatch restart on channel 2 runs into its timeout; pending then cleared.
    drv_irq_en = 4'b0100;
    drv_irq_clr = 4'b1111;
    drv_start[2] = 1'b1; drv_mode[2] = 2'b10; drv_limit[2] = 32'd100;
    for (int c = 0; c <= 111; c++) begin
      case (c)
        1: checkOutput("sw.irq_idle", longint'(bus_if.irq), 0);
        101: begin
          checkOutput("sw.count_101", dutCount(2), 100);
          checkOutput("sw.timeout_101", longint'(bus_if.ch_timeout[2]), 0);
        end
        102: begin
          checkOutput("sw.count_102", dutCount(2), 100);
          checkOutput("sw.timeout_102", longint'(bus_if.ch_timeout[2]), 1);
          checkOutput("sw.pend_102", longint'(bus_if.irq_pend[2]), 0);
        end
        103: begin
          checkOutput("sw.pend_103", longint'(bus_if.irq_pend[2]), 1);
          checkOutput("sw.irq_103", longint'(bus_if.irq), 1);
          drv_irq_clr[2] = 1'b1;
        end
        104: begin
          checkOutput("sw.pend_cleared", longint'(bus_if.irq_pend[2]), 0);
          checkOutput("sw.irq_cleared", longint'(bus_if.irq), 0);
          checkOutput("sw.timeout_level", longint'(bus_if.ch_timeout[2]), 1);
        end
        110: begin
          checkOutput("sw.count_saturated", dutCount(2), 100);
          drv_stop[2] = 1'b1;
        end
        111: begin
          checkOutput("sw.busy_hold", longint'(bus_if.ch_busy[2]), 0);
          checkOutput("sw.timeout_hold", longint'(bus_if.ch_timeout[2]), 1);
          checkOutput("sw.count_hold", dutCount(2), 100);
        end
        default: ;
      endcase
      if (c < 111) applyStimulus();
    end

    // Start+stop together restarts; clear coincident with done leaves pending set.
    drv_irq_en = 4'b0001;
    drv_start[0] = 1'b1; drv_mode[0] = 2'b01; drv_limit[0] = 32'd5;
    for (int c = 0; c <= 11; c++) begin
      case (c)
        3: begin
          checkOutput("ss.count_before", dutCount(0), 2);
          drv_start[0] = 1'b1;
          drv_stop[0] = 1'b1;
        end
        4: begin
          checkOutput("ss.count_restart", dutCount(0), 0);
          checkOutput("ss.busy_restart", longint'(bus_if.ch_busy[0]), 1);
        end
        5: begin
          checkOutput("ss.count_run", dutCount(0), 1);
          drv_irq_clr[0] = 1'b1;
        end
        6: checkOutput("ss.pend_clear", longint'(bus_if.irq_pend[0]), 0);
        9: begin
          checkOutput("ss.count_limit", dutCount(0), 5);
          checkOutput("ss.done_early", longint'(bus_if.ch_done[0]), 0);
        end
        10: begin
          checkOutput("ss.done", longint'(bus_if.ch_done[0]), 1);
          checkOutput("ss.count_wrap", dutCount(0), 0);
          drv_irq_clr[0] = 1'b1;
        end
        11: begin
          checkOutput("ss.pend_set_wins", longint'(bus_if.irq_pend[0]), 1);
          checkOutput("ss.irq", longint'(bus_if.irq), 1);
        end
        default: ;
      endcase
      if (c < 11) applyStimulus();
    end

    // Reset mid-operation clears every output; then timestamp ticks at 10, 20, 30.
    drv_rst = 1'b1;
    applyStimulus();
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("rst.ch%0d.count", i), dutCount(i), 0);
      checkOutput($sformatf("rst.ch%0d.busy", i), longint'(bus_if.ch_busy[i]), 0);
      checkOutput($sformatf("rst.ch%0d.timeout", i), longint'(bus_if.ch_timeout[i]), 0);
      checkOutput($sformatf("rst.ch%0d.pend", i), longint'(bus_if.irq_pend[i]), 0);
    end
    checkOutput("rst.timestamp", longint'(bus_if.timestamp), 0);
    checkOutput("rst.tick", longint'(bus_if.tick), 0);
    for (int c = 1; c <= 30; c++) begin
      applyStimulus();
      case (c)
        9:  checkOutput("ts.tick_9", longint'(bus_if.tick), 0);
        10: begin
          checkOutput("ts.tick_10", longint'(bus_if.tick), 1);
          checkOutput("ts.ts_10", longint'(bus_if.timestamp), 1);
        end
        11: checkOutput("ts.tick_11", longint'(bus_if.tick), 0);
        20: checkOutput("ts.tick_20", longint'(bus_if.tick), 1);
        29: checkOutput("ts.ts_29", longint'(bus_if.timestamp), 2);
        30: begin
          checkOutput("ts.tick_30", longint'(bus_if.tick), 1);
          checkOutput("ts.ts_30", longint'(bus_if.timestamp), 3);
        end
        default: ;
      endcase
    end

    // Reset asserted at cycle 25 restarts the prescaler from zero.
    drv_rst = 1'b1;
    applyStimulus();
    for (int c = 1; c <= 25; c++) applyStimulus();
    checkOutput("tsr.ts_25", longint'(bus_if.timestamp), 2);
    drv_rst = 1'b1;
    applyStimulus();
    checkOutput("tsr.ts_after_rst", longint'(bus_if.timestamp), 0);
    for (int c = 1; c <= 10; c++) begin
      applyStimulus();
      if (c == 9)  checkOutput("tsr.tick_9", longint'(bus_if.tick), 0);
      if (c == 10) checkOutput("tsr.tick_10", longint'(bus_if.tick), 1);
    end

    // Randomized traffic on all channels, checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        drv_start[i]   = ($urandom_range(0, 24) == 0);
        drv_stop[i]    = ($urandom_range(0, 29) == 0);
        drv_mode[i]    = 2'($urandom_range(0, 3));
        drv_irq_clr[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 63) == 0)     drv_limit[i] = '1;
        else if ($urandom_range(0, 3) == 0) drv_limit[i] = W'($urandom_range(0, 60));
        else                                drv_limit[i] = W'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 49) == 0) drv_irq_en = N'($urandom);
      drv_rst = ($urandom_range(0, 599) == 0);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
